// File: rtl/hash_arbiter.sv
// Round-robin front end that shares one mix_hash engine between NumReq requesters.
// Launches one job at a time, re-arms the engine after each job and tags results with the id.
module hash_arbiter #(
  parameter int unsigned NumReq  = 4,
  parameter int unsigned IdW     = 2,
  parameter int unsigned Timeout = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_i,
  input  logic [32*NumReq-1:0]   req_key_i,
  output logic [NumReq-1:0]      grant_o,
  output logic                   rsp_valid_o,
  output logic [31:0]            rsp_hash_o,
  output logic [IdW-1:0]         rsp_id_o,
  output logic                   rsp_err_o,
  output logic                   busy_o,
  output logic [31:0]            hash_num_o,
  output logic                   hash_start_o,
  output logic                   hash_reset_o,
  input  logic                   hash_done_i,
  input  logic [31:0]            hash_out_i
);

  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [7:0] TimeoutM1 = 8'(Timeout - 1);

  typedef enum logic [1:0] {StArm, StIdle, StLaunch, StWait} state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NumReq-1:0]   grant_q, grant_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [31:0]         rsp_hash_q, rsp_hash_d;
  logic [IdW-1:0]      rsp_id_q, rsp_id_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;
  logic [31:0]         hash_num_q, hash_num_d;
  logic                hash_start_q, hash_start_d;
  logic                hash_reset_q, hash_reset_d;

  logic                found;
  logic [PtrW-1:0]     winner;
  logic [PtrW-1:0]     idx;

  // First set request strictly after the last winner, wrapping at NumReq.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned off = 1; off <= NumReq; off++) begin
      idx = PtrW'((32'(ptr_q) + off) % NumReq);
      if (!found && req_i[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    grant_d      = '0;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_hash_d   = rsp_hash_q;
    rsp_id_d     = rsp_id_q;
    hash_num_d   = hash_num_q;
    hash_start_d = 1'b0;

    unique case (state_q)
      StArm: begin
        state_d = StIdle;
      end
      StIdle: begin
        if (found) begin
          state_d      = StLaunch;
          ptr_d        = winner;
          grant_d      = NumReq'(1) << winner;
          hash_num_d   = req_key_i[32*winner +: 32];
          rsp_id_d     = IdW'(winner);
          hash_start_d = 1'b1;
        end
      end
      StLaunch: begin
        state_d = StWait;
        cnt_d   = '0;
      end
      StWait: begin
        if (hash_done_i) begin
          rsp_hash_d  = hash_out_i;
          rsp_valid_d = 1'b1;
          state_d     = StArm;
        end else if (cnt_q == TimeoutM1) begin
          rsp_hash_d  = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = StArm;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StArm;
      end
    endcase

    // Outputs are registered, so they follow the state being entered.
    hash_reset_d = (state_d != StArm);
    busy_d       = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StArm;
      ptr_q        <= PtrW'(NumReq - 1);
      cnt_q        <= '0;
      grant_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_hash_q   <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      hash_num_q   <= '0;
      hash_start_q <= 1'b0;
      hash_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hash_q   <= rsp_hash_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      hash_num_q   <= hash_num_d;
      hash_start_q <= hash_start_d;
      hash_reset_q <= hash_reset_d;
    end
  end

  assign grant_o      = grant_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_hash_o   = rsp_hash_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = busy_q;
  assign hash_num_o   = hash_num_q;
  assign hash_start_o = hash_start_q;
  assign hash_reset_o = hash_reset_q;

endmodule
